// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_DRAIN
    } state_t;

    localparam int         CMD_RD_BIT = 7;
    localparam logic [7:0] DRAIN_FILL = 8'hFF;
    localparam logic [7:0] IDLE_FILL  = 8'h00;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Sequences SPI slave bytes into register-file writes and prefetched reads.
// Define SPI_REG_CTRL_STATUS_EN to return {rd_late, err_addr} while the command byte shifts.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int REG_COUNT = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rvalid,
    output logic              busy,
    output logic              err_addr,
    output logic              rd_late
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(REG_COUNT - 1);
    localparam logic [31:0]       REG_COUNT_U = 32'(REG_COUNT);

    state_t            state, state_n;
    logic              frame_q;
    logic [ADDR_W-1:0] addr, addr_n, reg_addr_n, cmd_addr;
    logic [7:0]        tx_n, reg_wdata_n, fill;
    logic              we_n, re_n, busy_n, err_n, late_n, cmd_ok;

    function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign cmd_addr = rx_data[ADDR_W-1:0];
    assign cmd_ok   = 32'(cmd_addr) < REG_COUNT_U;

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        tx_n        = tx_data;
        we_n        = 1'b0;
        re_n        = 1'b0;
        err_n       = err_addr;
        late_n      = rd_late;

        case (state)
            ST_IDLE: begin
                if (frame_active && !frame_q) state_n = ST_CMD;
            end
            ST_CMD: begin
                if (rx_valid) begin
                    addr_n = cmd_addr;
                    if (!cmd_ok) begin
                        err_n   = 1'b1;
                        state_n = ST_DRAIN;
                    end else if (rx_data[CMD_RD_BIT]) begin
                        state_n    = ST_RD_REQ;
                        reg_addr_n = cmd_addr;
                        re_n       = 1'b1;
                    end else begin
                        state_n = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (rx_valid) begin
                    we_n        = 1'b1;
                    reg_addr_n  = addr;
                    reg_wdata_n = rx_data;
                    addr_n      = inc_addr(addr);
                end
            end
            ST_RD_REQ: begin
                state_n = ST_RD_WAIT;
                if (rx_valid) late_n = 1'b1;
            end
            ST_RD_WAIT: begin
                // A response that arrives after its byte slot is still loaded for the next one.
                if (reg_rvalid) begin
                    tx_n    = reg_rdata;
                    addr_n  = inc_addr(addr);
                    state_n = ST_RD_HOLD;
                end else if (rx_valid) begin
                    late_n = 1'b1;
                end
            end
            ST_RD_HOLD: begin
                if (rx_valid) begin
                    state_n    = ST_RD_REQ;
                    reg_addr_n = addr;
                    re_n       = 1'b1;
                end
            end
            ST_DRAIN: ;
            default: state_n = ST_IDLE;
        endcase

        // Frame end wins over everything except a write strobe for the final byte.
        if (state != ST_IDLE && !frame_active) begin
            state_n = ST_IDLE;
            re_n    = 1'b0;
        end

`ifdef SPI_REG_CTRL_STATUS_EN
        fill = {6'b0, late_n, err_n};
`else
        fill = IDLE_FILL;
`endif

        case (state_n)
            ST_IDLE, ST_CMD: tx_n = fill;
            ST_DRAIN:        tx_n = DRAIN_FILL;
            ST_WR:           tx_n = IDLE_FILL;
            default:         ;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            frame_q   <= 1'b0;
            addr      <= '0;
            tx_data   <= IDLE_FILL;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            err_addr  <= 1'b0;
            rd_late   <= 1'b0;
        end else begin
            state     <= state_n;
            frame_q   <= frame_active;
            addr      <= addr_n;
            tx_data   <= tx_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
            busy      <= busy_n;
            err_addr  <= err_n;
            rd_late   <= late_n;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: 128-register and 64-register instances share stimulus.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_active, rx_valid, reg_rvalid;
    logic [7:0] rx_data, reg_rdata;

    logic [7:0] tx_data, reg_wdata, b_tx_data, b_reg_wdata;
    logic [6:0] reg_addr, b_reg_addr;
    logic       reg_we, reg_re, busy, err_addr, rd_late;
    logic       b_reg_we, b_reg_re, b_busy, b_err_addr, b_rd_late;

    int total = 0;
    int bad   = 0;
    int re_cnt = 0, b_we_cnt = 0, b_re_cnt = 0;
    int lat = 2;
    int rsp_cnt = 0;
    logic [6:0] rsp_addr = '0;

    spi_reg_ctrl #(.ADDR_W(7), .REG_COUNT(128)) dut (
        .clk(clk), .rst(rst), .frame_active(frame_active), .rx_valid(rx_valid),
        .rx_data(rx_data), .tx_data(tx_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
        .busy(busy), .err_addr(err_addr), .rd_late(rd_late)
    );

    spi_reg_ctrl #(.ADDR_W(7), .REG_COUNT(64)) dut64 (
        .clk(clk), .rst(rst), .frame_active(frame_active), .rx_valid(rx_valid),
        .rx_data(rx_data), .tx_data(b_tx_data), .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata),
        .reg_we(b_reg_we), .reg_re(b_reg_re), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
        .busy(b_busy), .err_addr(b_err_addr), .rd_late(b_rd_late)
    );

    always #5 clk = ~clk;

    // Register-file model: answers each reg_re of the 128-register instance after lat cycles.
    always @(negedge clk) begin
        reg_rvalid = 1'b0;
        if (reg_re) begin
            rsp_cnt  = lat;
            rsp_addr = reg_addr;
        end
        if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                reg_rvalid = 1'b1;
                reg_rdata  = 8'h10 + 8'(rsp_addr);
            end
        end
        if (reg_re)   re_cnt++;
        if (b_reg_we) b_we_cnt++;
        if (b_reg_re) b_re_cnt++;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [6:0] a0;
        logic [6:0] a1;
    } wvec_t;

    wvec_t wv[4];

    function automatic int idle_val(input logic late, input logic err);
`ifdef SPI_REG_CTRL_STATUS_EN
        return int'({6'b0, late, err});
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_frame();
        frame_active = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_frame();
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int re0, bwe0, bre0;

        wv[0] = '{cmd: 8'h05, d0: 8'hAA, d1: 8'h55, a0: 7'd5,   a1: 7'd6};
        wv[1] = '{cmd: 8'h7F, d0: 8'h11, d1: 8'h22, a0: 7'd127, a1: 7'd0};
        wv[2] = '{cmd: 8'h00, d0: 8'hC3, d1: 8'h3C, a0: 7'd0,   a1: 7'd1};
        wv[3] = '{cmd: 8'h3E, d0: 8'h01, d1: 8'hFE, a0: 7'd62,  a1: 7'd63};

        rst = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_data = '0;
        reg_rvalid = 1'b0; reg_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_flags", {err_addr, rd_late}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Read frame: 0x83 then dummies, 2-cycle response latency
        lat = 2;
        start_frame();
        chk("rd_busy", busy, 1);
        send_byte(8'h83, 0);
        chk("rd_re0", reg_re, 1);
        chk("rd_addr0", reg_addr, 3);
        repeat (3) @(negedge clk);
        chk("rd_tx0", tx_data, 8'h13);
        send_byte(8'h00, 0);
        chk("rd_re1", reg_re, 1);
        chk("rd_addr1", reg_addr, 4);
        repeat (3) @(negedge clk);
        chk("rd_tx1", tx_data, 8'h14);
        send_byte(8'h00, 0);
        chk("rd_re2", reg_re, 1);
        chk("rd_addr2", reg_addr, 5);
        repeat (3) @(negedge clk);
        chk("rd_tx2", tx_data, 8'h15);
        chk("rd_no_late", rd_late, 0);
        end_frame();
        chk("rd_end_busy", busy, 0);
        chk("rd_end_tx", tx_data, idle_val(1'b0, 1'b0));

        // Bad address on the 64-register instance
        chk("bad_err_before", b_err_addr, 0);
        bwe0 = b_we_cnt; bre0 = b_re_cnt;
        start_frame();
        send_byte(8'h50, 1);
        chk("bad_err", b_err_addr, 1);
        chk("bad_tx", b_tx_data, 8'hFF);
        send_byte(8'h12, 2);
        chk("bad_tx_drain", b_tx_data, 8'hFF);
        chk("bad_no_we", b_we_cnt - bwe0, 0);
        chk("bad_no_re", b_re_cnt - bre0, 0);
        end_frame();
        chk("bad_idle_tx", b_tx_data, idle_val(1'b0, 1'b1));
        chk("bad_err_sticky", b_err_addr, 1);

        // Write frames, including the wrap from 127 to 0
        for (int i = 0; i < 4; i++) begin
            re0 = re_cnt;
            start_frame();
            send_byte(wv[i].cmd, 1);
            send_byte(wv[i].d0, 0);
            chk("wr_we0", reg_we, 1);
            chk("wr_addr0", reg_addr, wv[i].a0);
            chk("wr_data0", reg_wdata, wv[i].d0);
            @(negedge clk);
            chk("wr_we0_pulse", reg_we, 0);
            send_byte(wv[i].d1, 0);
            chk("wr_we1", reg_we, 1);
            chk("wr_addr1", reg_addr, wv[i].a1);
            chk("wr_data1", reg_wdata, wv[i].d1);
            end_frame();
            chk("wr_no_re", re_cnt - re0, 0);
        end

        // Last byte arrives together with the frame end
        start_frame();
        send_byte(8'h20, 1);
        rx_valid = 1'b1; rx_data = 8'h9C; frame_active = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("fall_we", reg_we, 1);
        chk("fall_addr", reg_addr, 8'h20);
        chk("fall_data", reg_wdata, 8'h9C);
        chk("fall_busy", busy, 0);
        repeat (2) @(negedge clk);

        // Late read response
        lat = 6;
        start_frame();
        send_byte(8'h81, 1);
        send_byte(8'h00, 0);
        chk("late_flag", rd_late, 1);
        chk("late_tx_old", tx_data, 0);
        repeat (8) @(negedge clk);
        chk("late_tx_loaded", tx_data, 8'h11);
        send_byte(8'h00, 0);
        chk("late_next_re", reg_re, 1);
        chk("late_next_addr", reg_addr, 2);
        repeat (8) @(negedge clk);
        end_frame();
        chk("late_sticky", rd_late, 1);

        // Abort while waiting for read data
        lat = 4;
        start_frame();
        send_byte(8'h84, 0);
        chk("abort_re", reg_re, 1);
        @(negedge clk);
        frame_active = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_tx", tx_data, idle_val(1'b1, 1'b0));
        repeat (3) @(negedge clk);
        chk("abort_tx_after_rvalid", tx_data, idle_val(1'b1, 1'b0));
        chk("abort_busy_after", busy, 0);

        // Reset in the middle of a write
        lat = 2;
        start_frame();
        send_byte(8'h10, 0);
        send_byte(8'h77, 0);
        chk("mid_we", reg_we, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_we", reg_we, 0);
        chk("mid_rst_addr", reg_addr, 0);
        chk("mid_rst_wdata", reg_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx", tx_data, 0);
        chk("mid_rst_flags", {err_addr, rd_late, reg_re}, 0);
        chk("mid_rst_err64", b_err_addr, 0);
        frame_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
